// File: rtl/msg_reader_tx_pkg.sv
// Shared types and defaults for the message reader / UART transmitter.
package msg_reader_tx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 4;
  localparam int unsigned MSG_LEN_DEF      = 10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StStop,
    StDone
  } state_e;

endpackage

// File: rtl/msg_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick on the last count.
module msg_bit_timer
  import msg_reader_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;

  always_comb begin
    o_tick     = !i_clear && (r_cnt == CntMax);
    w_cnt_next = (i_clear || o_tick) ? '0 : r_cnt + CntW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/msg_reader_tx.sv
// Reads MSG_LEN characters from an external ROM and sends each as an 8N1 serial frame.
module msg_reader_tx
  import msg_reader_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned MSG_LEN      = MSG_LEN_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic [3:0] o_rom_addr,
  input  logic [7:0] i_rom_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [3:0] LastAddr = 4'(MSG_LEN - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_next;
  logic [3:0] r_addr;
  logic [3:0] w_addr_next;
  logic       r_tx;
  logic       w_tx_next;
  logic       w_tick;
  logic       w_timer_clear;

  msg_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(w_timer_clear),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StFetch;
      StFetch: w_state_next = StStart;
      StStart: if (w_tick) w_state_next = StData;
      StData:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_next = StStop;
      StStop:  if (w_tick) w_state_next = (r_addr == LastAddr) ? StDone : StFetch;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_addr_next    = r_addr;
    unique case (r_state)
      StFetch: begin
        w_shift_next   = i_rom_data;
        w_bit_cnt_next = 3'd0;
      end
      StData: begin
        if (w_tick) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
        end
      end
      StStop:  if (w_tick && (r_addr != LastAddr)) w_addr_next = r_addr + 4'd1;
      StDone:  w_addr_next = 4'd0;
      default: ;
    endcase
  end

  // tx is registered from the next state so the line changes exactly with the state.
  always_comb begin
    o_busy        = (r_state != StIdle);
    o_done        = (r_state == StDone);
    w_timer_clear = !((r_state == StStart) || (r_state == StData) || (r_state == StStop));
    unique case (w_state_next)
      StStart: w_tx_next = 1'b0;
      StData:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift   <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_addr    <= 4'd0;
      r_tx      <= 1'b1;
    end else begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_addr    <= w_addr_next;
      r_tx      <= w_tx_next;
    end
  end

  assign o_rom_addr = r_addr;
  assign o_tx       = r_tx;

endmodule

// File: tb/tb_msg_reader_tx.sv
// Directed bench for msg_reader_tx: cycle vector table for the first frame plus message-level runs.
module tb_msg_reader_tx;

  localparam int CPB      = 4;
  localparam int CHAR_CYC = 1 + 10 * CPB;

  typedef struct {
    logic       start;
    logic       tx;
    logic       busy;
    logic       done;
    logic [3:0] addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [3:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       obs_tx, obs_busy, obs_done;
  logic [3:0] obs_addr;
  logic [7:0] rom     [16];
  logic [7:0] exp_msg [16];
  vec_t       vecs    [44];
  int         sel = 0;
  int         n_vec = 0;
  int         n_err = 0;

  assign data_a = rom[addr_a];
  assign data_b = rom[addr_b];

  always_comb begin
    if (sel == 0) begin
      obs_tx = tx_a; obs_busy = busy_a; obs_done = done_a; obs_addr = addr_a;
    end else begin
      obs_tx = tx_b; obs_busy = busy_b; obs_done = done_b; obs_addr = addr_b;
    end
  end

  msg_reader_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(10)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_rom_addr(addr_a),
    .i_rom_data(data_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );

  msg_reader_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(12)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_rom_addr(addr_b),
    .i_rom_data(data_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );

  always #5 clk = ~clk;

  function automatic int pack(input logic tx, input logic busy, input logic done,
                              input logic [3:0] addr);
    return {25'd0, tx, busy, done, addr};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start_a = v;
    else start_b = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start, record tx while busy, then decode frames from the line alone.
  task automatic run_msg(input int n_chars, input int pulse_at, input int exp_busy,
                         input string tag);
    logic       txs[$];
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         nb = 0;
    int         i;
    bit         ended = 1'b0;
    logic [7:0] b;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    while (!ended && cyc < 3000) begin
      if (obs_busy) begin
        busy_cnt++;
        txs.push_back(obs_tx);
      end else if (busy_cnt > 0) begin
        ended = 1'b1;
      end
      if (obs_done) done_cnt++;
      if (!ended) begin
        if (cyc == pulse_at) set_start(1'b1);
        else if (cyc == pulse_at + 1) set_start(1'b0);
        cyc++;
        @(negedge clk);
      end
    end
    set_start(1'b0);
    chk({tag, "_ended"}, int'(ended), 1);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_addr_idle"}, int'(obs_addr), 0);
    i = 1;
    while (i + 39 < txs.size()) begin
      if (txs[i] == 1'b0 && txs[i-1] == 1'b1) begin
        for (int k = 0; k < 8; k++) b[k] = txs[i + CPB * (k + 1) + 2];
        if (nb < 16) chk($sformatf("%s_byte%0d", tag, nb), int'(b), int'(exp_msg[nb]));
        nb++;
        i += 10 * CPB;
      end else begin
        i++;
      end
    end
    chk({tag, "_byte_count"}, nb, n_chars);
  endtask

  initial begin
    int         w;
    logic [7:0] first_ch;
    int         idx;

    exp_msg = '{8'h41, 8'h53, 8'h53, 8'h49, 8'h47, 8'h4E, 8'h4D, 8'h45,
                8'h4E, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rom     = '{8'h41, 8'h53, 8'h53, 8'h49, 8'h47, 8'h4E, 8'h4D, 8'h45,
                8'h4E, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // First frame 'A' cycle by cycle; a start pulse inside DATA must be ignored.
    first_ch = 8'h41;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    for (int k = 2; k < 6; k++) vecs[k] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    for (int bi = 0; bi < 8; bi++) begin
      for (int c = 0; c < CPB; c++) begin
        idx = 6 + CPB * bi + c;
        vecs[idx] = '{(idx == 20), first_ch[bi], 1'b1, 1'b0, 4'd0};
      end
    end
    for (int k = 38; k < 42; k++) vecs[k] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[42] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
    vecs[43] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1};

    repeat (2) @(negedge clk);
    chk("reset_state", pack(obs_tx, obs_busy, obs_done, obs_addr), pack(1'b1, 1'b0, 1'b0, 4'd0));
    rst = 1'b0;
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("vec%0d", k), pack(obs_tx, obs_busy, obs_done, obs_addr),
          pack(vecs[k].tx, vecs[k].busy, vecs[k].done, vecs[k].addr));
      start_a = vecs[k].start;
      @(negedge clk);
    end
    start_a = 1'b0;
    do_reset();

    run_msg(10, -1, 10 * CHAR_CYC + 1, "msg");
    run_msg(10, 2 * CHAR_CYC + 10, 10 * CHAR_CYC + 1, "msg_pulse");

    // Abort inside DATA of character 5 (0x47, bit 3 is 0).
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    w = 0;
    while (obs_addr != 4'd4 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("reach_char5", int'(w < 1000), 1);
    repeat (18) @(negedge clk);
    chk("pre_abort", pack(obs_tx, obs_busy, obs_done, obs_addr), pack(1'b0, 1'b1, 1'b0, 4'd4));
    #2 rst = 1'b1;
    #1;
    chk("abort_async", pack(obs_tx, obs_busy, obs_done, obs_addr), pack(1'b1, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", pack(obs_tx, obs_busy, obs_done, obs_addr),
        pack(1'b1, 1'b0, 1'b0, 4'd0));
    run_msg(10, -1, 10 * CHAR_CYC + 1, "after_abort");

    // Held start: one IDLE cycle after DONE, then FETCH, then the start bit.
    @(negedge clk);
    start_a = 1'b1;
    w = 0;
    while (!obs_done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("hold_done_seen", int'(w < 1000), 1);
    @(negedge clk);
    chk("hold_gap_idle", pack(obs_tx, obs_busy, obs_done, obs_addr),
        pack(1'b1, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    chk("hold_fetch", pack(obs_tx, obs_busy, obs_done, obs_addr), pack(1'b1, 1'b1, 1'b0, 4'd0));
    @(negedge clk);
    chk("hold_start_bit", int'(obs_tx), 0);
    start_a = 1'b0;
    do_reset();

    sel = 1;
    run_msg(12, -1, 12 * CHAR_CYC + 1, "msg12");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
